nano_rv32i_core: RTL and testbench

Multi-cycle RV32I integer core: fetches from a synchronous-read instruction memory and does word loads and stores on a separate synchronous data memory. It is the processor at the centre of the nano_rv32i system, alongside the `i_memory` and `d_memory` blocks. Each instruction takes 2 cycles, or 3 for loads. There is no pipeline, no interrupts and no CSRs.

---
 rtl/nano_rv32i_pkg.sv | 55 +++++
 rtl/nano_rv32i_if.sv | 21 ++
 rtl/nano_rv32i_regfile.sv | 23 ++
 rtl/nano_rv32i_core.sv | 189 ++++++++++++++++++
 tb/tb_nano_rv32i_core.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nano_rv32i_pkg.sv
// Shared definitions for the nano_rv32i core: opcodes, funct codes, FSM states and ALU ops.
// NANO_RV32I_HALT_EN adds the HALT state and the ECALL/EBREAK encodings.
package nano_rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

`ifdef NANO_RV32I_HALT_EN
    localparam logic [2:0]  F3_PRIV    = 3'b000;
    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;
`endif

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_LOAD_WB
`ifdef NANO_RV32I_HALT_EN
        , ST_HALT
`endif
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

endpackage

// File: rtl/nano_rv32i_if.sv
// Instruction and data memory bus of the nano_rv32i core; the core is the master.
interface nano_rv32i_if;
    logic [31:0] i_addr_o;
    logic        i_rd_o;
    logic [31:0] i_data_i;
    logic [31:0] d_addr_o;
    logic        d_rd_o;
    logic [31:0] d_data_i;
    logic        d_wr_o;
    logic [31:0] d_data_o;

    modport master (
        output i_addr_o, i_rd_o, d_addr_o, d_rd_o, d_wr_o, d_data_o,
        input  i_data_i, d_data_i
    );

    modport slave (
        input  i_addr_o, i_rd_o, d_addr_o, d_rd_o, d_wr_o, d_data_o,
        output i_data_i, d_data_i
    );
endinterface

// File: rtl/nano_rv32i_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 reads as zero.
module nano_rv32i_regfile (
    input  logic        clk,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o
);
    logic [31:0] regs_q [32];

    // Contents are deliberately not reset; x0 is never written so it can stay unreset too.
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];
endmodule

// File: rtl/nano_rv32i_core.sv
// Multi-cycle RV32I core: FETCH/EXEC (plus LOAD_WB for loads), no pipeline.
// Define NANO_RV32I_HALT_EN to make ECALL/EBREAK halt the core and add the halt_o port.
module nano_rv32i_core
    import nano_rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    nano_rv32i_if.master bus
`ifdef NANO_RV32I_HALT_EN
    ,
    output logic         halt_o
`endif
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  load_rd_q, load_rd_d;

    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_y, addr_sum, pc_plus4;
    logic        rf_we, br_taken;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    alu_op_e     alu_op;

    // The fetched word is consumed straight from the memory in EXEC, never latched.
    assign instr  = bus.i_data_i;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign pc_plus4 = pc_q + 32'd4;
    assign addr_sum = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign alu_b    = (opcode == OPC_OP) ? rs2_val : imm_i;

    nano_rv32i_regfile u_regfile (
        .clk      (clk_i),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata),
        .raddr1_i (rs1),
        .rdata1_o (rs1_val),
        .raddr2_i (rs2),
        .rdata2_o (rs2_val)
    );

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            F3_ADD_SUB: alu_op = (opcode == OPC_OP && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_op = ALU_SLL;
            F3_SLT:     alu_op = ALU_SLT;
            F3_SLTU:    alu_op = ALU_SLTU;
            F3_XOR:     alu_op = ALU_XOR;
            F3_SR:      alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_op = ALU_OR;
            F3_AND:     alu_op = ALU_AND;
            default:    alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_y = 32'd0;
        case (alu_op)
            ALU_ADD:  alu_y = rs1_val + alu_b;
            ALU_SUB:  alu_y = rs1_val - alu_b;
            ALU_SLL:  alu_y = rs1_val << alu_b[4:0];
            ALU_SLT:  alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, rs1_val < alu_b};
            ALU_XOR:  alu_y = rs1_val ^ alu_b;
            ALU_SRL:  alu_y = rs1_val >> alu_b[4:0];
            ALU_SRA:  alu_y = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
            ALU_OR:   alu_y = rs1_val | alu_b;
            ALU_AND:  alu_y = rs1_val & alu_b;
            default:  alu_y = 32'd0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val < rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        load_rd_d    = load_rd_q;
        rf_we        = 1'b0;
        rf_waddr     = rd;
        rf_wdata     = alu_y;
        bus.i_rd_o   = 1'b0;
        bus.i_addr_o = 32'd0;
        bus.d_rd_o   = 1'b0;
        bus.d_wr_o   = 1'b0;
        bus.d_addr_o = 32'd0;
        bus.d_data_o = 32'd0;
        case (state_q)
            ST_INIT: state_d = ST_FETCH;
            ST_FETCH: begin
                bus.i_rd_o   = 1'b1;
                bus.i_addr_o = pc_q;
                state_d      = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_plus4;
                case (opcode)
                    OPC_LUI:    begin rf_we = 1'b1; rf_wdata = imm_u; end
                    OPC_AUIPC:  begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
                    OPC_JAL:    begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = pc_q + imm_j; end
                    OPC_JALR:   begin rf_we = 1'b1; rf_wdata = pc_plus4; pc_d = addr_sum & ~32'd1; end
                    OPC_BRANCH: pc_d = br_taken ? (pc_q + imm_b) : pc_plus4;
                    OPC_OP_IMM, OPC_OP: rf_we = 1'b1;
                    OPC_LOAD: begin
                        bus.d_rd_o   = 1'b1;
                        bus.d_addr_o = addr_sum;
                        load_rd_d    = rd;
                        pc_d         = pc_q;
                        state_d      = ST_LOAD_WB;
                    end
                    OPC_STORE: begin
                        bus.d_wr_o   = 1'b1;
                        bus.d_addr_o = addr_sum;
                        bus.d_data_o = rs2_val;
                    end
`ifdef NANO_RV32I_HALT_EN
                    OPC_SYSTEM: begin
                        if (funct3 == F3_PRIV && rs1 == 5'd0 && rd == 5'd0 &&
                            (instr[31:20] == F12_ECALL || instr[31:20] == F12_EBREAK)) begin
                            pc_d    = pc_q;
                            state_d = ST_HALT;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            ST_LOAD_WB: begin
                rf_we    = 1'b1;
                rf_waddr = load_rd_q;
                rf_wdata = bus.d_data_i;
                pc_d     = pc_plus4;
                state_d  = ST_FETCH;
            end
`ifdef NANO_RV32I_HALT_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            pc_q      <= RESET_PC;
            load_rd_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            load_rd_q <= load_rd_d;
        end
    end

`ifdef NANO_RV32I_HALT_EN
    assign halt_o = (state_q == ST_HALT);
`endif
endmodule

// File: tb/tb_nano_rv32i_core.sv
// Scoreboard bench for nano_rv32i_core: directed programs, expected bus events queued up front
// and checked by a monitor. Build with NANO_RV32I_HALT_EN to exercise the HALT state.
module tb_nano_rv32i_core;
    logic clk;
    logic rst;
`ifdef NANO_RV32I_HALT_EN
    logic halt;
`endif

    nano_rv32i_if bus ();

    nano_rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef NANO_RV32I_HALT_EN
        ,
        .halt_o(halt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    // Synchronous-read instruction and data memories; low address bits ignored.
    always @(posedge clk) begin
        if (bus.i_rd_o) bus.i_data_i <= imem[bus.i_addr_o[7:2]];
        if (bus.d_wr_o) dmem[bus.d_addr_o[7:2]] <= bus.d_data_o;
        if (bus.d_rd_o) bus.d_data_i <= dmem[bus.d_addr_o[7:2]];
    end

    typedef struct {
        byte         kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  tcyc;
    int  cur_cyc;

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h13);
    endfunction

    task automatic exp_fetch(input logic [31:0] a);
        ev_t e;
        e.kind = "F"; e.addr = a; e.data = 32'd0; e.cyc = tcyc;
        exp_q.push_back(e);
        cur_cyc = tcyc;
        tcyc += 2;
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = "W"; e.addr = a; e.data = d; e.cyc = cur_cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic exp_load(input logic [31:0] a);
        ev_t e;
        e.kind = "R"; e.addr = a; e.data = 32'd0; e.cyc = cur_cyc + 1;
        exp_q.push_back(e);
        tcyc += 1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check_output({name, "_strobes"}, {29'd0, bus.i_rd_o, bus.d_rd_o, bus.d_wr_o}, 32'd0);
        check_output({name, "_iaddr"}, bus.i_addr_o, 32'd0);
    endtask

    // Asserts reset (asynchronously, possibly mid-instruction) and clears program and scoreboard.
    task automatic start_prog(input string name);
        #1 rst = 1'b1;
        #1 check_idle({name, "_async_rst"});
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        exp_q.delete();
        tcyc = 1;
    endtask

    task automatic apply_stimulus(input string name);
        repeat (2) begin
            @(negedge clk);
            check_idle({name, "_rst"});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle({name, "_init"});
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        check_output({name, "_drain"}, exp_q.size(), 32'd0);
    endtask

    initial begin : monitor
        int          mcyc;
        ev_t         e;
        byte         k;
        logic [31:0] a;
        logic [31:0] d;
        mcyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mcyc = 0;
            end else begin
                if (bus.i_rd_o || bus.d_rd_o || bus.d_wr_o) begin
                    check_output("strobe_excl",
                                 32'(bus.i_rd_o) + 32'(bus.d_rd_o) + 32'(bus.d_wr_o), 32'd1);
                    k = bus.i_rd_o ? "F" : (bus.d_rd_o ? "R" : "W");
                    a = bus.i_rd_o ? bus.i_addr_o : bus.d_addr_o;
                    d = bus.d_wr_o ? bus.d_data_o : 32'd0;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL unexpected_event: got %c addr=%h data=%h cyc=%0d, required none",
                                 k, a, d, mcyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.addr !== a || e.data !== d || e.cyc != mcyc) begin
                            n_fail++;
                            $display("[TB] FAIL bus_event: got %c addr=%h data=%h cyc=%0d, required %c addr=%h data=%h cyc=%0d",
                                     k, a, d, mcyc, e.kind, e.addr, e.data, e.cyc);
                        end
                    end
                end
                mcyc++;
            end
        end
    end

    initial begin : main
        rst = 1'b1;

        // ALU: add, signed/unsigned compare, negative immediate
        start_prog("alu");
        imem[0] = addi(1, 0, 5);
        imem[1] = addi(2, 0, -3);
        imem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
        imem[3] = enc_r(7'h00, 1, 2, 3'b011, 4);
        imem[4] = enc_s(0, 3, 0);
        imem[5] = enc_s(4, 4, 0);
        imem[6] = enc_r(7'h00, 1, 2, 3'b010, 6);
        imem[7] = enc_s(8, 6, 0);
        imem[8] = enc_s(12, 2, 0);
        exp_fetch(0); exp_fetch(4); exp_fetch(8); exp_fetch(12);
        exp_fetch(16); exp_store(32'h0, 32'h2);
        exp_fetch(20); exp_store(32'h4, 32'h0);
        exp_fetch(24);
        exp_fetch(28); exp_store(32'h8, 32'h1);
        exp_fetch(32); exp_store(32'hC, 32'hFFFF_FFFD);
        apply_stimulus("alu");

        // Shifts, LUI/AUIPC and logic ops
        start_prog("shift");
        imem[0]  = {20'h80000, 5'd1, 7'h37};
        imem[1]  = enc_i(32'h404, 1, 3'b101, 2, 7'h13);
        imem[2]  = enc_i(32'h004, 1, 3'b101, 3, 7'h13);
        imem[3]  = {20'h00001, 5'd4, 7'h17};
        imem[4]  = enc_s(0, 2, 0);
        imem[5]  = enc_s(4, 3, 0);
        imem[6]  = enc_s(8, 4, 0);
        imem[7]  = addi(5, 0, 32'h35);
        imem[8]  = addi(6, 0, 32'h0F);
        imem[9]  = enc_r(7'h20, 5, 6, 3'b000, 7);
        imem[10] = enc_r(7'h00, 6, 5, 3'b100, 8);
        imem[11] = enc_r(7'h00, 6, 5, 3'b111, 9);
        imem[12] = enc_r(7'h00, 6, 5, 3'b110, 10);
        imem[13] = enc_r(7'h00, 5, 6, 3'b001, 11);
        for (int i = 0; i < 5; i++) imem[14 + i] = enc_s(12 + 4 * i, 5'(7 + i), 0);
        exp_fetch(0); exp_fetch(4); exp_fetch(8); exp_fetch(12);
        exp_fetch(16); exp_store(32'h0, 32'hF800_0000);
        exp_fetch(20); exp_store(32'h4, 32'h0800_0000);
        exp_fetch(24); exp_store(32'h8, 32'h0000_100C);
        for (int i = 7; i < 14; i++) exp_fetch(4 * i);
        exp_fetch(56); exp_store(32'h0C, 32'hFFFF_FFDA);
        exp_fetch(60); exp_store(32'h10, 32'h0000_003A);
        exp_fetch(64); exp_store(32'h14, 32'h0000_0005);
        exp_fetch(68); exp_store(32'h18, 32'h0000_003F);
        exp_fetch(72); exp_store(32'h1C, 32'h01E0_0000);
        apply_stimulus("shift");

        // Store then load back through the data memory, 3-cycle loads
        start_prog("ldst");
        imem[0] = addi(1, 0, 32'h40);
        imem[1] = enc_s(4, 1, 1);
        imem[2] = enc_i(4, 1, 3'b010, 5, 7'h03);
        imem[3] = addi(6, 5, 1);
        imem[4] = enc_s(8, 6, 1);
        imem[5] = enc_i(8, 1, 3'b010, 7, 7'h03);
        imem[6] = enc_s(0, 7, 0);
        exp_fetch(0);
        exp_fetch(4);  exp_store(32'h44, 32'h40);
        exp_fetch(8);  exp_load(32'h44);
        exp_fetch(12);
        exp_fetch(16); exp_store(32'h48, 32'h41);
        exp_fetch(20); exp_load(32'h48);
        exp_fetch(24); exp_store(32'h0, 32'h41);
        apply_stimulus("ldst");

        // Branches (signed vs unsigned on -1) and JALR with bit 0 cleared
        start_prog("branch");
        imem[0] = enc_b(8, 0, 0, 3'b000);
        imem[1] = addi(7, 0, 1);
        imem[2] = addi(2, 0, -1);
        imem[3] = enc_b(8, 0, 2, 3'b100);
        imem[4] = addi(7, 0, 2);
        imem[5] = enc_b(8, 0, 2, 3'b110);
        imem[6] = enc_b(8, 0, 2, 3'b111);
        imem[7] = addi(7, 0, 3);
        imem[8] = enc_i(3, 0, 3'b000, 0, 7'h67);
        exp_fetch(0); exp_fetch(8); exp_fetch(12); exp_fetch(20);
        exp_fetch(24); exp_fetch(32); exp_fetch(2);
        apply_stimulus("branch");

        // JAL link value, backward jump, BNE taken and JALR link
        start_prog("jal");
        imem[0] = enc_j(16, 0);
        imem[4] = enc_j(-8, 1);
        imem[2] = enc_s(0, 1, 0);
        imem[3] = enc_b(12, 0, 1, 3'b001);
        imem[6] = enc_i(8, 1, 3'b000, 3, 7'h67);
        imem[7] = enc_s(4, 3, 0);
        exp_fetch(0); exp_fetch(16);
        exp_fetch(8);  exp_store(32'h0, 32'h14);
        exp_fetch(12); exp_fetch(24);
        exp_fetch(28); exp_store(32'h4, 32'h1C);
        apply_stimulus("jal");

        // x0 is never written; all-zero word, SYSTEM and unknown opcodes fall through
        start_prog("nop");
        imem[0] = addi(0, 0, 7);
        imem[2] = enc_s(0, 0, 0);
`ifndef NANO_RV32I_HALT_EN
        imem[3] = 32'h0000_0073;
        imem[4] = 32'h0010_0073;
`endif
        imem[5] = 32'h0000_000B;
        imem[6] = addi(1, 0, 9);
        imem[7] = enc_s(4, 1, 0);
        exp_fetch(0); exp_fetch(4);
        exp_fetch(8); exp_store(32'h0, 32'h0);
        exp_fetch(12); exp_fetch(16); exp_fetch(20); exp_fetch(24);
        exp_fetch(28); exp_store(32'h4, 32'h9);
        apply_stimulus("nop");

`ifdef NANO_RV32I_HALT_EN
        // EBREAK halts; nothing is fetched until reset restarts at 0
        start_prog("halt");
        check_output("halt_in_reset", {31'd0, halt}, 32'd0);
        imem[0] = addi(1, 0, 1);
        imem[1] = addi(2, 0, 2);
        imem[2] = 32'h0010_0073;
        exp_fetch(0); exp_fetch(4); exp_fetch(8);
        apply_stimulus("halt");
        repeat (10) @(posedge clk);
        check_output("halt_o", {31'd0, halt}, 32'd1);
        start_prog("restart");
        check_output("halt_cleared", {31'd0, halt}, 32'd0);
        imem[0] = addi(1, 0, 1);
        imem[1] = enc_s(0, 0, 0);
        exp_fetch(0);
        exp_fetch(4); exp_store(32'h0, 32'h0);
        apply_stimulus("restart");
`endif

        #1 rst = 1'b1;
        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
